ycbcr_point_proc: RTL and testbench
===================================

Name: ycbcr_point_proc

Overview:
Parametrised successor to the fixed bypass/Sobel selection stage. It is a frame-synchronous, per-pixel YCbCr processing stage that sits between rgb2ycbcr and ycbcr2rgb. Mode and coefficients change only at frame start, so a mid-frame switch cannot tear the image. All paths share one fixed, parametrisable latency, so vs/hs/de stay aligned with the data in every mode.

Parameters:
DW, 8, component width in bits (Y, Cb, Cr each).
PIPE_EXTRA, 0, extra pure-delay stages appended so the latency can match a parallel path (0..16).
VS_ACT, 1, active level of vs_in; frame start = transition of vs_in into this level.

Ports:
clk  in  1  pixel clock.
rst_b  in  1  asynchronous reset, active-high.
vs_in  in  1  vertical sync.
hs_in  in  1  horizontal sync.
de_in  in  1  data enable.
y_in  in  DW  luma.
cb_in  in  DW  blue-difference chroma (offset binary).
cr_in  in  DW  red-difference chroma (offset binary).
mode  in  3  requested mode; sampled at frame start only.
offset  in  DW+1  signed two's-complement brightness offset; sampled at frame start only.
thresh  in  DW  binarize threshold; sampled at frame start only.
vs_out  out  1  delayed vs.
hs_out  out  1  delayed hs.
de_out  out  1  delayed de.
y_out  out  DW  processed luma.
cb_out  out  DW  processed Cb.
cr_out  out  DW  processed Cr.
mode_active  out  3  mode currently applied to pixels entering the pipe.
frame_cnt  out  16  frame-start counter.

Behaviour:
- Reset (async, rst_b=1):
  - All outputs, pipeline registers and shadow registers go to 0.
  - mode_active=0 (bypass), frame_cnt=0.
  - Internal vs history register = inactive level (~VS_ACT).
- Frame-start detect:
  - fs = (vs_in==VS_ACT) && (vs_d1!=VS_ACT), where vs_d1 is vs_in registered once.
  - If vs_in is already active when reset releases, no fs is seen until vs_in goes inactive and active again.
- On the fs cycle (clock edge where fs=1):
  - mode_active<=mode, offset_s<=offset, thresh_s<=thresh, frame_cnt<=frame_cnt+1 (wraps 0xFFFF->0).
  - The pixel presented in the same cycle as fs is processed with the OLD shadow values.
  - New values apply from the next input cycle.
- Mid-frame changes on mode/offset/thresh have no effect until the next fs.
- Latency: 2+PIPE_EXTRA clocks, input to every output, for vs/hs/de and data alike, in all modes.
  - Stage 1: register inputs plus the shadow values in use.
  - Stage 2: compute and register the result.
  - Then PIPE_EXTRA plain delay stages.
- Constants: MAX=2^DW-1, MID=2^(DW-1).
- Modes (applied per pixel):
  - 0 bypass: outputs = inputs.
  - 1 gray: Y passes; Cb=Cr=MID.
  - 2 invert: Y=MAX-Y, Cb=MAX-Cb, Cr=MAX-Cr.
  - 3 brightness: Y=clamp(Y+offset_s, 0, MAX), computed in DW+2-bit signed arithmetic; Cb/Cr pass.
  - 4 binarize: Y=(Y>=thresh_s)?MAX:0; Cb=Cr=MID.
  - 5..7 reserved: behave as bypass; mode_active still reports the raw value.
- Blanking: when the delayed de is 0, y_out/cb_out/cr_out=0 regardless of mode. Sync signals are never modified.
- Back-to-back fs (vs toggling every cycle) is legal: each active edge updates the shadows and increments frame_cnt.
- Reset asserted mid-frame:
  - Immediate async clear.
  - The pipe drains as zeros.
  - The first valid output after release appears 2+PIPE_EXTRA clocks after the first de_in=1.

Test Plan:
- Reset and latency (DW=8, PIPE_EXTRA=0, mode=0 before first vs): assert rst_b, drive de=1 and Y/Cb/Cr=0x12/0x34/0x56. Required: all outputs 0 during reset; after release the same values and de_out=1 appear exactly 2 clocks later; frame_cnt=0.
- Frame-synchronous switch: mode=1 set mid-frame with Cb=0x20 on input. Required: cb_out stays 0x20 until the next vs rising edge. From the first post-fs pixel, cb_out=cr_out=0x80, mode_active=1, frame_cnt=1.
- Brightness saturation, mode=3: offset=+100, Y=200 -> y_out=255; offset=-100 (9'h19C), Y=50 -> y_out=0; offset=+10, Y=100 -> y_out=110.
- Invert/binarize: mode=2, Y/Cb/Cr=0x00/0x80/0xFF -> 0xFF/0x7F/0x00. mode=4 with thresh=128: Y=127 -> 0x00, Y=128 -> 0xFF; Cb=Cr=0x80.
- Blanking and PIPE_EXTRA=3: de_in=0 with nonzero data gives zero data outputs; every transition on vs/hs/de emerges exactly 5 clocks later; reserved mode=6 gives bypass output.
- Reset mid-frame plus a vs already high at release: assert rst_b during an active line. Required: outputs clear immediately, no fs occurs until vs_in goes low and high again, and frame_cnt then reads 1.

Source files
------------

// File: rtl/ycbcr_point_proc.sv
// Frame-synchronous per-pixel YCbCr point processor (bypass/gray/invert/brightness/binarize).
// Mode and coefficients are shadowed at frame start; every path has latency 2+PIPE_EXTRA.
module ycbcr_point_proc #(
    parameter int   DW         = 8,
    parameter int   PIPE_EXTRA = 0,
    parameter logic VS_ACT     = 1'b1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          vs_in,
    input  logic          hs_in,
    input  logic          de_in,
    input  logic [DW-1:0] y_in,
    input  logic [DW-1:0] cb_in,
    input  logic [DW-1:0] cr_in,
    input  logic [2:0]    mode,
    input  logic [DW:0]   offset,
    input  logic [DW-1:0] thresh,
    output logic          vs_out,
    output logic          hs_out,
    output logic          de_out,
    output logic [DW-1:0] y_out,
    output logic [DW-1:0] cb_out,
    output logic [DW-1:0] cr_out,
    output logic [2:0]    mode_active,
    output logic [15:0]   frame_cnt
);

    localparam logic [DW-1:0] MAX = {DW{1'b1}};
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
    localparam logic [2:0] MODE_GRAY     = 3'd1;
    localparam logic [2:0] MODE_INVERT   = 3'd2;
    localparam logic [2:0] MODE_BRIGHT   = 3'd3;
    localparam logic [2:0] MODE_BINARIZE = 3'd4;
    localparam int PW = 3 + 3 * DW;

    logic          r_vs_d1;
    logic          r_armed;
    logic          w_fs;
    logic [2:0]    r_mode_s;
    logic [DW:0]   r_offset_s;
    logic [DW-1:0] r_thresh_s;
    logic [15:0]   r_frame_cnt;

    logic          r_s1_vs, r_s1_hs, r_s1_de;
    logic [DW-1:0] r_s1_y, r_s1_cb, r_s1_cr;
    logic [2:0]    r_s1_mode;
    logic [DW:0]   r_s1_offset;
    logic [DW-1:0] r_s1_thresh;

    logic signed [DW+1:0] w_sum;
    logic [DW-1:0] w_y, w_cb, w_cr;

    logic [PW-1:0] r_pipe [0:PIPE_EXTRA];

    // r_armed blocks a false frame start when vs is already active as reset releases
    assign w_fs = (vs_in == VS_ACT) && (r_vs_d1 != VS_ACT) && r_armed;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_vs_d1     <= ~VS_ACT;
            r_armed     <= 1'b0;
            r_mode_s    <= '0;
            r_offset_s  <= '0;
            r_thresh_s  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_vs_d1 <= vs_in;
            if (vs_in != VS_ACT) begin
                r_armed <= 1'b1;
            end
            if (w_fs) begin
                r_mode_s    <= mode;
                r_offset_s  <= offset;
                r_thresh_s  <= thresh;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_s1_vs     <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_y      <= '0;
            r_s1_cb     <= '0;
            r_s1_cr     <= '0;
            r_s1_mode   <= '0;
            r_s1_offset <= '0;
            r_s1_thresh <= '0;
        end else begin
            r_s1_vs     <= vs_in;
            r_s1_hs     <= hs_in;
            r_s1_de     <= de_in;
            r_s1_y      <= y_in;
            r_s1_cb     <= cb_in;
            r_s1_cr     <= cr_in;
            r_s1_mode   <= r_mode_s;
            r_s1_offset <= r_offset_s;
            r_s1_thresh <= r_thresh_s;
        end
    end

    always_comb begin
        w_sum = $signed({2'b00, r_s1_y}) + $signed({r_s1_offset[DW], r_s1_offset});
        w_y   = r_s1_y;
        w_cb  = r_s1_cb;
        w_cr  = r_s1_cr;
        case (r_s1_mode)
            MODE_GRAY: begin
                w_cb = MID;
                w_cr = MID;
            end
            MODE_INVERT: begin
                w_y  = MAX - r_s1_y;
                w_cb = MAX - r_s1_cb;
                w_cr = MAX - r_s1_cr;
            end
            MODE_BRIGHT: begin
                // sum range is -2^DW .. 2*MAX, so bit DW alone flags overflow when non-negative
                if (w_sum[DW+1]) begin
                    w_y = '0;
                end else if (w_sum[DW]) begin
                    w_y = MAX;
                end else begin
                    w_y = w_sum[DW-1:0];
                end
            end
            MODE_BINARIZE: begin
                w_y  = (r_s1_y >= r_s1_thresh) ? MAX : '0;
                w_cb = MID;
                w_cr = MID;
            end
            default: begin
            end
        endcase
        if (!r_s1_de) begin
            w_y  = '0;
            w_cb = '0;
            w_cr = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i <= PIPE_EXTRA; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {r_s1_vs, r_s1_hs, r_s1_de, w_y, w_cb, w_cr};
            for (int i = 1; i <= PIPE_EXTRA; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {vs_out, hs_out, de_out, y_out, cb_out, cr_out} = r_pipe[PIPE_EXTRA];
    assign mode_active = r_mode_s;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ycbcr_point_proc.sv
// Bench for ycbcr_point_proc: two instances (PIPE_EXTRA 0 and 3) against a queue-based
// reference model, plus directed vectors with hand-computed results.
module tb_ycbcr_point_proc;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs_i, hs_i, de_i;
    logic [7:0] y_i, cb_i, cr_i;
    logic [2:0] mode_i;
    logic [8:0] off_i;
    logic [7:0] thr_i;

    logic       o0_vs, o0_hs, o0_de, o3_vs, o3_hs, o3_de;
    logic [7:0] o0_y, o0_cb, o0_cr, o3_y, o3_cb, o3_cr;
    logic [2:0] o0_mode, o3_mode;
    logic [15:0] o0_fc, o3_fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ycbcr_point_proc #(.DW(8), .PIPE_EXTRA(0), .VS_ACT(1'b1)) u_dut0 (
        .clk(clk), .rst_b(rst), .vs_in(vs_i), .hs_in(hs_i), .de_in(de_i),
        .y_in(y_i), .cb_in(cb_i), .cr_in(cr_i), .mode(mode_i), .offset(off_i), .thresh(thr_i),
        .vs_out(o0_vs), .hs_out(o0_hs), .de_out(o0_de), .y_out(o0_y), .cb_out(o0_cb), .cr_out(o0_cr),
        .mode_active(o0_mode), .frame_cnt(o0_fc));

    ycbcr_point_proc #(.DW(8), .PIPE_EXTRA(3), .VS_ACT(1'b1)) u_dut3 (
        .clk(clk), .rst_b(rst), .vs_in(vs_i), .hs_in(hs_i), .de_in(de_i),
        .y_in(y_i), .cb_in(cb_i), .cr_in(cr_i), .mode(mode_i), .offset(off_i), .thresh(thr_i),
        .vs_out(o3_vs), .hs_out(o3_hs), .de_out(o3_de), .y_out(o3_y), .cb_out(o3_cb), .cr_out(o3_cr),
        .mode_active(o3_mode), .frame_cnt(o3_fc));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pix_t;

    function automatic pix_t ref_pix(input logic vs, input logic hs, input logic de,
                                     input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                                     input logic [2:0] md, input logic [8:0] off, input logic [7:0] thr);
        pix_t p;
        int   t;
        p.vs = vs; p.hs = hs; p.de = de; p.y = y; p.cb = cb; p.cr = cr;
        case (md)
            3'd1: begin p.cb = 8'd128; p.cr = 8'd128; end
            3'd2: begin p.y = 8'd255 - y; p.cb = 8'd255 - cb; p.cr = 8'd255 - cr; end
            3'd3: begin
                t = int'(y) + (off[8] ? int'(off) - 512 : int'(off));
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                p.y = t[7:0];
            end
            3'd4: begin p.y = (y >= thr) ? 8'd255 : 8'd0; p.cb = 8'd128; p.cr = 8'd128; end
            default: ;
        endcase
        if (!de) begin p.y = 0; p.cb = 0; p.cr = 0; end
        return p;
    endfunction

    pix_t        q0[$];
    pix_t        q3[$];
    logic [2:0]  m_mode;
    logic [8:0]  m_off;
    logic [7:0]  m_thr;
    logic [15:0] m_fcnt;
    logic        m_prev_low;   // last sampled vs (since reset) was inactive
    logic        mon_en = 1'b0;
    pix_t        m_p;
    pix_t        e0, e3;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_off = 0; m_thr = 0; m_fcnt = 0; m_prev_low = 1'b0;
            q0.delete(); q3.delete();
            repeat (2) q0.push_back('0);
            repeat (5) q3.push_back('0);
            mon_en = 1'b1;
        end else begin
            m_p = ref_pix(vs_i, hs_i, de_i, y_i, cb_i, cr_i, m_mode, m_off, m_thr);
            q0.push_back(m_p); void'(q0.pop_front());
            q3.push_back(m_p); void'(q3.pop_front());
            if (vs_i && m_prev_low) begin
                m_mode = mode_i; m_off = off_i; m_thr = thr_i; m_fcnt = m_fcnt + 16'd1;
            end
            m_prev_low = !vs_i;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            e0 = rst ? '0 : q0[0];
            e3 = rst ? '0 : q3[0];
            chk("mdl_pix0", {5'd0, o0_vs, o0_hs, o0_de, o0_y, o0_cb, o0_cr}, {5'd0, e0});
            chk("mdl_pix3", {5'd0, o3_vs, o3_hs, o3_de, o3_y, o3_cb, o3_cr}, {5'd0, e3});
            chk("mdl_mode0", {29'd0, o0_mode}, {29'd0, rst ? 3'd0 : m_mode});
            chk("mdl_mode3", {29'd0, o3_mode}, {29'd0, rst ? 3'd0 : m_mode});
            chk("mdl_fcnt0", {16'd0, o0_fc}, {16'd0, rst ? 16'd0 : m_fcnt});
            chk("mdl_fcnt3", {16'd0, o3_fc}, {16'd0, rst ? 16'd0 : m_fcnt});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_frame(input logic [2:0] md, input logic [8:0] off, input logic [7:0] thr);
        mode_i = md; off_i = off; thr_i = thr;
        vs_i = 1'b0; tick(1);
        vs_i = 1'b1; tick(1);
    endtask

    task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        de_i = 1'b1; y_i = y; cb_i = cb; cr_i = cr;
    endtask

    initial begin
        rst = 1'b1;
        vs_i = 0; hs_i = 0; de_i = 1; y_i = 8'h12; cb_i = 8'h34; cr_i = 8'h56;
        mode_i = 0; off_i = 0; thr_i = 0;
        tick(2);
        chk("rst_de", {31'd0, o0_de}, 32'd0);
        chk("rst_y", {24'd0, o0_y}, 32'd0);
        chk("rst_fc", {16'd0, o0_fc}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk("lat_1clk_de", {31'd0, o0_de}, 32'd0);
        tick(1);
        chk("lat_2clk_de", {31'd0, o0_de}, 32'd1);
        chk("lat_2clk_ycbcr", {8'd0, o0_y, o0_cb, o0_cr}, 32'h00123456);
        chk("lat_fc", {16'd0, o0_fc}, 32'd0);

        // mid-frame mode request has no effect until vs rises
        mode_i = 3'd1; cb_i = 8'h20;
        tick(3);
        chk("midframe_cb", {24'd0, o0_cb}, 32'h20);
        chk("midframe_mode", {29'd0, o0_mode}, 32'd0);
        vs_i = 1'b1;
        tick(1);
        chk("fs_mode", {29'd0, o0_mode}, 32'd1);
        chk("fs_fc", {16'd0, o0_fc}, 32'd1);
        tick(1);
        chk("fs_pixel_old", {24'd0, o0_cb}, 32'h20);
        tick(1);
        chk("gray_cbcr", {16'd0, o0_cb, o0_cr}, 32'h8080);

        new_frame(3'd3, 9'd100, 8'd0);
        px(8'd200, 8'h40, 8'h50);
        tick(2); chk("bright_sat_hi", {24'd0, o0_y}, 32'd255);
        tick(3); chk("bright_sat_hi3", {24'd0, o3_y}, 32'd255);
        new_frame(3'd3, 9'h19C, 8'd0);
        px(8'd50, 8'h40, 8'h50);
        tick(2); chk("bright_sat_lo", {24'd0, o0_y}, 32'd0);
        new_frame(3'd3, 9'd10, 8'd0);
        px(8'd100, 8'h40, 8'h50);
        tick(2); chk("bright_mid", {8'd0, o0_y, o0_cb, o0_cr}, {8'd0, 8'd110, 8'h40, 8'h50});

        new_frame(3'd2, 9'd0, 8'd0);
        px(8'h00, 8'h80, 8'hFF);
        tick(2); chk("invert", {8'd0, o0_y, o0_cb, o0_cr}, 32'h00FF7F00);
        new_frame(3'd4, 9'd0, 8'd128);
        px(8'd127, 8'h10, 8'h20);
        tick(2); chk("bin_127", {8'd0, o0_y, o0_cb, o0_cr}, 32'h00008080);
        px(8'd128, 8'h10, 8'h20);
        tick(2); chk("bin_128", {8'd0, o0_y, o0_cb, o0_cr}, 32'h00FF8080);

        de_i = 1'b0; y_i = 8'hAA; cb_i = 8'hBB; cr_i = 8'hCC;
        tick(5);
        chk("blank3", {8'd0, o3_y, o3_cb, o3_cr}, 32'd0);
        chk("blank0", {8'd0, o0_y, o0_cb, o0_cr}, 32'd0);
        hs_i = 1'b1; de_i = 1'b1; vs_i = 1'b0;
        tick(4);
        chk("sync_4clk", {29'd0, o3_vs, o3_hs, o3_de}, 32'b100);
        tick(1);
        chk("sync_5clk", {29'd0, o3_vs, o3_hs, o3_de}, 32'b011);
        hs_i = 1'b0;

        new_frame(3'd6, 9'd0, 8'd0);
        px(8'h11, 8'h22, 8'h33);
        tick(5);
        chk("reserved_bypass", {8'd0, o3_y, o3_cb, o3_cr}, 32'h00112233);
        chk("reserved_mode", {29'd0, o3_mode}, 32'd6);

        mode_i = 3'd2;
        for (int i = 0; i < 3; i++) begin
            vs_i = 1'b0; tick(1);
            vs_i = 1'b1; tick(1);
        end
        chk("b2b_fc", {16'd0, o0_fc}, 32'd10);
        chk("b2b_mode", {29'd0, o0_mode}, 32'd2);

        px(8'h55, 8'h66, 8'h77);
        tick(3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_clr0", {15'd0, o0_de, o0_y, o0_cb}, 32'd0);
        chk("async_clr3", {31'd0, o3_de}, 32'd0);
        chk("async_clr_fc", {13'd0, o0_mode, o0_fc}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("vs_high_no_fs", {16'd0, o0_fc}, 32'd0);
        vs_i = 1'b0; tick(1);
        vs_i = 1'b1; tick(1);
        chk("vs_rearm_fs", {16'd0, o0_fc}, 32'd1);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
